// File: rtl/seg7_pkg.sv
// Shared types, mode codes and hex-to-segment map for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    localparam logic [1:0] MODE_A     = 2'd0;
    localparam logic [1:0] MODE_B     = 2'd1;
    localparam logic [1:0] MODE_SPLIT = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    localparam int unsigned NUM_DIGITS = 8;

    // Active-low segments {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with per-frame source snapshot,
// blanking guard between digits, leading-zero suppression and A/B alternation.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned ALT_FRAMES   = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_en,
    input  logic [1:0]  i_mode,
    input  logic        i_lzb,
    input  logic [31:0] i_val_a,
    input  logic [31:0] i_val_b,
    input  logic [7:0]  i_dp,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame
);

    localparam int unsigned DWELL_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W     = $clog2(DWELL_MAX + 1);
    localparam int unsigned FCNT_W    = $clog2(ALT_FRAMES + 1);

    localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [FCNT_W-1:0] ALT_LAST   = FCNT_W'(ALT_FRAMES - 1);
    localparam logic [2:0]        LAST_IDX   = 3'(NUM_DIGITS - 1);

    scan_state_e        state;
    logic [2:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic [FCNT_W-1:0]  fcnt;
    logic               alt_b;
    logic [1:0]         mode_q;
    logic [63:0]        snap;

    logic [31:0]        word_c;
    logic [31:0]        upper_c;
    logic [3:0]         nibble_c;
    logic [6:0]         dig_seg_c;
    logic               blank_c;

    // Word currently on display, chosen from the frame snapshot
    always_comb begin
        word_c = snap[31:0];
        case (mode_q)
            MODE_B:     word_c = snap[63:32];
            MODE_SPLIT: word_c = {snap[47:32], snap[15:0]};
            MODE_ALT:   word_c = alt_b ? snap[63:32] : snap[31:0];
            default:    word_c = snap[31:0];
        endcase
    end

    // A digit is a leading zero when it and everything above it is zero
    always_comb begin
        upper_c  = word_c >> {idx, 2'b00};
        nibble_c = upper_c[3:0];
        blank_c  = i_lzb && (idx != 3'd0) && (upper_c == 32'd0);
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_c),
        .seg_c  (dig_seg_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            cnt     <= '0;
            fcnt    <= '0;
            alt_b   <= 1'b0;
            mode_q  <= MODE_A;
            snap    <= 64'd0;
            o_an    <= 8'hFF;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else if (!i_en) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            cnt     <= '0;
            fcnt    <= '0;
            alt_b   <= 1'b0;
            o_an    <= 8'hFF;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            o_an    <= 8'hFF;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
            case (state)
                ST_IDLE: begin
                    snap   <= {i_val_b, i_val_a};
                    mode_q <= i_mode;
                    idx    <= 3'd0;
                    cnt    <= '0;
                    state  <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= ST_ON;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    o_an  <= ~(8'd1 << idx);
                    o_seg <= blank_c ? 7'h7F : dig_seg_c;
                    o_dp  <= ~i_dp[idx];
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= ST_BLANK;
                        if (idx == LAST_IDX) begin
                            // Frame boundary: new snapshot, mode and alternation step
                            o_frame <= 1'b1;
                            idx     <= 3'd0;
                            snap    <= {i_val_b, i_val_a};
                            mode_q  <= i_mode;
                            if (i_mode != MODE_ALT) begin
                                fcnt  <= '0;
                                alt_b <= 1'b0;
                            end else if (mode_q == MODE_ALT) begin
                                if (fcnt == ALT_LAST) begin
                                    fcnt  <= '0;
                                    alt_b <= ~alt_b;
                                end else begin
                                    fcnt <= fcnt + FCNT_W'(1);
                                end
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

    localparam int ON_C    = 4;
    localparam int BLANK_C = 1;
    localparam int ALT_F   = 2;
    localparam int SLOT    = ON_C + BLANK_C;
    localparam int FRAME   = 8 * SLOT;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_en = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic        i_lzb = 1'b0;
    logic [31:0] i_val_a = 32'd0;
    logic [31:0] i_val_b = 32'd0;
    logic [7:0]  i_dp = 8'd0;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: position within the frame and the captured frame inputs
    bit          m_act = 1'b0;
    int          m_pos = 0;
    int          m_k = 0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [1:0]  m_mode = 2'd0;

    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_frame = 1'b0;

    seg7_scan_ctrl #(
        .ON_CYCLES    (ON_C),
        .BLANK_CYCLES (BLANK_C),
        .ALT_FRAMES   (ALT_F)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (i_en),
        .i_mode  (i_mode),
        .i_lzb   (i_lzb),
        .i_val_a (i_val_a),
        .i_val_b (i_val_b),
        .i_dp    (i_dp),
        .o_an    (o_an),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_frame (o_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word();
        case (m_mode)
            2'd0:    return m_a;
            2'd1:    return m_b;
            2'd2:    return {m_b[15:0], m_a[15:0]};
            default: return ((m_k / ALT_F) % 2 == 1) ? m_b : m_a;
        endcase
    endfunction

    // Model: pins after each edge reflect the frame position held during the cycle before it
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_act = 1'b0; m_k = 0;
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
            end else begin
                automatic int d = m_pos / SLOT;
                automatic bit lit = (m_pos % SLOT) >= BLANK_C;
                automatic logic [31:0] up = ref_word() >> (4 * d);
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
                if (!i_en) begin
                    m_act = 1'b0; m_k = 0;
                end else if (!m_act) begin
                    m_act = 1'b1; m_pos = 0;
                    m_a = i_val_a; m_b = i_val_b; m_mode = i_mode;
                end else begin
                    if (lit) begin
                        e_an  = ~(8'd1 << d);
                        e_seg = (i_lzb && d > 0 && up == 32'd0) ? 7'h7F : HEX_TAB[up[3:0]];
                        e_dp  = ~i_dp[d];
                    end
                    if (m_pos == FRAME - 1) begin
                        e_frame = 1'b1;
                        m_pos = 0;
                        if (i_mode == 2'd3 && m_mode == 2'd3) m_k++;
                        else if (i_mode != 2'd3) m_k = 0;
                        m_a = i_val_a; m_b = i_val_b; m_mode = i_mode;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("an", 32'(o_an), 32'(e_an));
            chk("seg", 32'(o_seg), 32'(e_seg));
            chk("dp", 32'(o_dp), 32'(e_dp));
            chk("frame", 32'(o_frame), 32'(e_frame));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        run(3);
        rstn = 1'b1;

        // Plain hex on source A
        i_en = 1'b1; i_val_a = 32'h89AB_CDEF; i_val_b = 32'h0123_4567;
        run(90);

        // Mid-frame source change must wait for the next frame
        i_val_a = 32'h1111_1111;
        run(60);
        i_val_a = 32'h2222_2222;
        run(60);

        // Split mode with leading-zero blanking, then all zero
        i_mode = 2'd2; i_lzb = 1'b1; i_val_a = 32'h0000_1234; i_val_b = 32'h0000_ABCD;
        run(90);
        i_val_a = 32'd0; i_val_b = 32'd0;
        run(90);

        // Alternate mode, then back to A
        i_mode = 2'd3; i_lzb = 1'b0; i_val_a = 32'd0; i_val_b = 32'hFFFF_FFFF;
        run(260);
        i_mode = 2'd0;
        run(90);

        // Enable dropped mid-frame, then restored
        run(23);
        i_en = 1'b0;
        run(5);
        i_en = 1'b1; i_val_a = 32'h0BAD_F00D;
        run(90);

        // Decimal points and async reset while a digit is lit
        i_dp = 8'h81;
        run(60);
        begin
            automatic int waited = 0;
            while (o_an == 8'hFF && waited < 50) begin
                run(1);
                waited++;
            end
            chk("lit_before_rst", 32'(o_an != 8'hFF), 32'd1);
        end
        #2 rstn = 1'b0;
        #1;
        chk("arst_an", 32'(o_an), 32'h0000_00FF);
        chk("arst_seg", 32'(o_seg), 32'h0000_007F);
        chk("arst_dp", 32'(o_dp), 32'd1);
        chk("arst_frame", 32'(o_frame), 32'd0);
        run(2);
        rstn = 1'b1;
        run(90);

        // Randomized traffic
        repeat (60) begin
            i_val_a = $urandom >> $urandom_range(0, 31);
            i_val_b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) i_mode = 2'($urandom_range(0, 3));
            i_lzb = 1'($urandom_range(0, 1));
            i_dp  = 8'($urandom);
            i_en  = ($urandom_range(0, 9) != 0);
            run($urandom_range(1, 70));
        end
        i_en = 1'b1; i_mode = 2'd3;
        run(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
